// File: rtl/zigbee_pkg.sv
// Shared types and constants for the receive frame synchroniser.
package zigbee_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PHR     = 2'd1,
      PAYLOAD = 2'd2
   } frame_state_t;

   localparam logic [7:0]  SFD_DEFAULT      = 8'hA7;
   localparam int unsigned PHR_LEN_W        = 7;
   localparam int unsigned MAX_PAYLOAD_BITS = 1016;
   localparam int unsigned PAY_CNT_W        = $clog2(MAX_PAYLOAD_BITS + 1);

endpackage

// File: rtl/rx_frame_sync_if.sv
// Bit-stream bus between CDR, frame synchroniser and RX FIFO.
interface rx_frame_sync_if;
   import zigbee_pkg::*;

   logic                 en_i;
   logic                 data_i;
   logic                 valid_i;
   logic                 data_o;
   logic                 valid_o;
   logic [PHR_LEN_W-1:0] len_o;
   logic                 frame_start_o;
   logic                 frame_end_o;
   logic                 err_o;
   logic                 busy_o;

   modport master (
      output en_i, data_i, valid_i,
      input  data_o, valid_o, len_o, frame_start_o, frame_end_o, err_o, busy_o
   );

   modport slave (
      input  en_i, data_i, valid_i,
      output data_o, valid_o, len_o, frame_start_o, frame_end_o, err_o, busy_o
   );
endinterface

// File: rtl/sfd_correlator.sv
// Preamble + SFD correlator: a shift register fed LSB first with a match
// flag evaluated on the value after the current shift.
module sfd_correlator #(
   parameter int unsigned PREAMBLE_MIN = 16,
   parameter logic [7:0]  SFD          = 8'hA7
) (
   input  logic clk,
   input  logic resetn,
   input  logic shift_i,
   input  logic clear_i,
   input  logic data_i,
   output logic match_c
);
   localparam int unsigned W      = PREAMBLE_MIN + 8;
   localparam int unsigned FILL_W = $clog2(W + 1);

   // The oldest bit of the W-bit window is dropped on every shift and never
   // observed, so only the upper W-1 bits are kept as state.
   logic [W-2:0]    sr_q, sr_d;
   logic [W-1:0]    sr_shift;
   // Bits shifted since the last clear; a cleared register is not preamble.
   logic [FILL_W-1:0] fill_q, fill_d;

   assign sr_shift = {data_i, sr_q};

   // Match requires a full window of fresh bits: zeros below, SFD on top.
   assign match_c = shift_i
                 && (fill_q >= FILL_W'(W - 1))
                 && (sr_shift[W-1:PREAMBLE_MIN] == SFD)
                 && (sr_shift[PREAMBLE_MIN-1:0] == '0);

   // Next window contents and fill count.
   always_comb begin
      sr_d   = sr_q;
      fill_d = fill_q;
      if (clear_i) begin
         sr_d   = '0;
         fill_d = '0;
      end else if (shift_i) begin
         sr_d = sr_shift[W-1:1];
         if (fill_q != FILL_W'(W)) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   // Window and fill registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr_q   <= '0;
         fill_q <= '0;
      end else begin
         sr_q   <= sr_d;
         fill_q <= fill_d;
      end
   end
endmodule

// File: rtl/rx_frame_sync.sv
// Receive frame synchroniser: hunts preamble+SFD, captures the PHR length,
// forwards len*8 payload bits and aborts on bad length or stalled input.
module rx_frame_sync
   import zigbee_pkg::*;
#(
   parameter int unsigned PREAMBLE_MIN = 16,
   parameter logic [7:0]  SFD          = SFD_DEFAULT,
   parameter int unsigned MAX_LEN      = 127,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic             clk,
   input  logic             resetn,
   rx_frame_sync_if.slave   bus
);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   frame_state_t          state_q, state_d;
   logic [PHR_LEN_W-1:0]  phr_q, phr_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [PAY_CNT_W-1:0]  pay_cnt_q, pay_cnt_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;
   logic                  data_q, data_d;
   logic                  valid_q, valid_d;
   logic [PHR_LEN_W-1:0]  len_q, len_d;
   logic                  start_q, start_d;
   logic                  end_q, end_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  sr_shift;
   logic                  sr_clear;
   logic                  match_c;

   // The window only moves while hunting; it is held clear inside a frame so
   // that every return to HUNT demands a complete new preamble.
   assign sr_shift = bus.en_i && bus.valid_i && (state_q == HUNT);
   assign sr_clear = !bus.en_i || (state_q != HUNT);

   sfd_correlator #(
      .PREAMBLE_MIN (PREAMBLE_MIN),
      .SFD          (SFD)
   ) u_corr (
      .clk     (clk),
      .resetn  (resetn),
      .shift_i (sr_shift),
      .clear_i (sr_clear),
      .data_i  (bus.data_i),
      .match_c (match_c)
   );

   // Next state, counters and output pulses.
   always_comb begin
      state_d   = state_q;
      phr_d     = phr_q;
      bit_cnt_d = bit_cnt_q;
      pay_cnt_d = pay_cnt_q;
      idle_d    = '0;
      data_d    = 1'b0;
      valid_d   = 1'b0;
      len_d     = len_q;
      start_d   = 1'b0;
      end_d     = 1'b0;
      err_d     = 1'b0;

      if (!bus.en_i) begin
         state_d = HUNT;
      end else begin
         case (state_q)
            HUNT: begin
               if (match_c) begin
                  state_d   = PHR;
                  bit_cnt_d = '0;
               end
            end
            PHR: begin
               if (bus.valid_i) begin
                  // phr_q already holds bits 0..6 when the 8th (reserved) bit lands.
                  phr_d     = {bus.data_i, phr_q[PHR_LEN_W-1:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if ((phr_q == '0) || (32'(phr_q) > MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                     end else begin
                        len_d     = phr_q;
                        start_d   = 1'b1;
                        pay_cnt_d = PAY_CNT_W'({phr_q, 3'b000});
                        state_d   = PAYLOAD;
                     end
                  end
               end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
            end
            PAYLOAD: begin
               if (bus.valid_i) begin
                  data_d    = bus.data_i;
                  valid_d   = 1'b1;
                  pay_cnt_d = pay_cnt_q - PAY_CNT_W'(1);
                  if (pay_cnt_q == PAY_CNT_W'(1)) begin
                     end_d   = 1'b1;
                     state_d = HUNT;
                  end
               end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end

      busy_d = (state_d != HUNT);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= HUNT;
         phr_q     <= '0;
         bit_cnt_q <= '0;
         pay_cnt_q <= '0;
         idle_q    <= '0;
         data_q    <= 1'b0;
         valid_q   <= 1'b0;
         len_q     <= '0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phr_q     <= phr_d;
         bit_cnt_q <= bit_cnt_d;
         pay_cnt_q <= pay_cnt_d;
         idle_q    <= idle_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         len_q     <= len_d;
         start_q   <= start_d;
         end_q     <= end_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.data_o        = data_q;
   assign bus.valid_o       = valid_q;
   assign bus.len_o         = len_q;
   assign bus.frame_start_o = start_q;
   assign bus.frame_end_o   = end_q;
   assign bus.err_o         = err_q;
   assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_rx_frame_sync.sv
// Scoreboard bench for rx_frame_sync: the driver queues the output event
// each bit must produce (with its cycle); a negedge monitor pops and compares.
module tb_rx_frame_sync;
   import zigbee_pkg::*;

   localparam int TIMEOUT = 64;

   typedef enum int {K_NONE, K_DATA, K_START, K_END, K_ERR} kind_t;

   typedef struct {
      int         cyc;
      logic       valid;
      logic       data;
      logic       start;
      logic       fend;
      logic       err;
      logic [6:0] len;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   int   last_edge = 0;
   logic [6:0] exp_len = '0;
   exp_t exp_q[$];

   rx_frame_sync_if bus ();

   rx_frame_sync #(
      .PREAMBLE_MIN (16),
      .SFD          (8'hA7),
      .MAX_LEN      (127),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every output event must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && (bus.valid_o || bus.frame_start_o || bus.frame_end_o || bus.err_o)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output cyc=%0d: got v=%b d=%b start=%b end=%b err=%b len=%0d, required no event",
                     cyc, bus.valid_o, bus.data_o, bus.frame_start_o, bus.frame_end_o, bus.err_o, bus.len_o);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.valid !== bus.valid_o || e.data !== bus.data_o ||
                e.start !== bus.frame_start_o || e.fend !== bus.frame_end_o ||
                e.err !== bus.err_o || e.len !== bus.len_o) begin
               n_err++;
               $display("FAIL scoreboard: got cyc=%0d v=%b d=%b start=%b end=%b err=%b len=%0d, required cyc=%0d v=%b d=%b start=%b end=%b err=%b len=%0d",
                        cyc, bus.valid_o, bus.data_o, bus.frame_start_o, bus.frame_end_o, bus.err_o, bus.len_o,
                        e.cyc, e.valid, e.data, e.start, e.fend, e.err, e.len);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Called at a negedge; the bit is sampled on the next posedge, and the
   // following call lands exactly 'gap' edges later.
   task automatic send_bit(input logic b, input int gap, input kind_t kind);
      exp_t e;
      last_edge = cyc + 1;
      if (kind != K_NONE) begin
         e.cyc   = last_edge;
         e.valid = (kind == K_DATA) || (kind == K_END);
         e.data  = e.valid ? b : 1'b0;
         e.start = (kind == K_START);
         e.fend  = (kind == K_END);
         e.err   = (kind == K_ERR);
         e.len   = exp_len;
         exp_q.push_back(e);
      end
      bus.valid_i = 1'b1;
      bus.data_i  = b;
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.data_i  = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   // Preamble zeros, SFD, PHR and the first nsend payload bits.
   task automatic send_frame(input int npre, input logic [7:0] phr, input int nbits,
                             input int nsend, input int gap, input logic [1023:0] pay,
                             input bit accept);
      logic [7:0] sfd;
      kind_t      k;
      bit         bad;
      sfd = SFD_DEFAULT;
      bad = (phr[6:0] == 7'd0);
      for (int i = 0; i < npre; i++) send_bit(1'b0, gap, K_NONE);
      for (int i = 0; i < 8; i++) send_bit(sfd[i], gap, K_NONE);
      for (int i = 0; i < 8; i++) begin
         k = K_NONE;
         if (accept && i == 7) begin
            if (bad) begin
               k = K_ERR;
            end else begin
               exp_len = phr[6:0];
               k = K_START;
            end
         end
         send_bit(phr[i], gap, k);
      end
      for (int i = 0; i < nsend; i++) begin
         k = K_NONE;
         if (accept && !bad) k = (i == nbits - 1) ? K_END : K_DATA;
         send_bit(pay[i], gap, k);
      end
   endtask

   initial begin
      logic [1023:0] pay;
      logic [1023:0] alt;
      exp_t          e;
      alt = {128{8'h5A}};

      resetn      = 1'b0;
      bus.en_i    = 1'b0;
      bus.data_i  = 1'b0;
      bus.valid_i = 1'b0;
      #1;
      chk("reset_busy",  int'(bus.busy_o), 0);
      chk("reset_valid", int'(bus.valid_o), 0);
      chk("reset_len",   int'(bus.len_o), 0);
      chk("reset_err",   int'(bus.err_o), 0);
      chk("reset_start", int'(bus.frame_start_o), 0);
      repeat (3) @(negedge clk);
      resetn   = 1'b1;
      bus.en_i = 1'b1;
      @(negedge clk);

      // Nominal frame, one bit every 24 cycles.
      for (int i = 0; i < 1024; i++) pay[i] = 1'($urandom);
      send_frame(16, 8'h03, 24, 24, 24, pay, 1'b1);
      repeat (4) @(negedge clk);
      chk("nominal_busy_after", int'(bus.busy_o), 0);
      chk("nominal_len", int'(bus.len_o), 3);

      // 15 zeros is one short of a preamble.
      send_frame(15, 8'h03, 24, 24, 2, alt, 1'b0);
      // Long preamble is accepted.
      send_frame(40, 8'h03, 24, 24, 2, alt, 1'b1);
      // Preamble + SFD pattern inside the payload is just data.
      pay = '0;
      pay[23:16] = 8'hA7;
      pay[31:24] = 8'hFF;
      send_frame(16, 8'h04, 32, 32, 1, pay, 1'b1);

      // Bad lengths, then a good frame.
      send_frame(16, 8'h00, 0, 0, 2, alt, 1'b1);
      send_frame(16, 8'h80, 0, 0, 2, alt, 1'b1);
      repeat (2) @(negedge clk);
      chk("badlen_busy", int'(bus.busy_o), 0);
      chk("badlen_len_held", int'(bus.len_o), 4);
      send_frame(16, 8'h02, 16, 16, 1, alt, 1'b1);

      // Timeout after 5 payload bits.
      send_frame(16, 8'h03, 24, 5, 4, alt, 1'b1);
      e.cyc = last_edge + TIMEOUT; e.valid = 1'b0; e.data = 1'b0;
      e.start = 1'b0; e.fend = 1'b0; e.err = 1'b1; e.len = exp_len;
      exp_q.push_back(e);
      repeat (TIMEOUT + 16) @(negedge clk);
      chk("timeout_busy", int'(bus.busy_o), 0);

      // Every bit lands exactly on the would-be expiry cycle.
      send_frame(16, 8'h02, 16, 16, TIMEOUT, alt, 1'b1);

      // Maximum length, back-to-back bits.
      for (int i = 0; i < 1024; i++) pay[i] = 1'($urandom);
      send_frame(16, 8'h7F, 1016, 1016, 1, pay, 1'b1);
      repeat (2) @(negedge clk);
      chk("max_len", int'(bus.len_o), 127);

      // en_i drop mid-payload truncates silently.
      send_frame(16, 8'h04, 32, 10, 2, alt, 1'b1);
      chk("en_pre_busy", int'(bus.busy_o), 1);
      bus.en_i = 1'b0;
      @(negedge clk);
      chk("en_drop_busy", int'(bus.busy_o), 0);
      bus.en_i = 1'b1;
      for (int i = 10; i < 32; i++) send_bit(alt[i], 2, K_NONE);
      send_frame(16, 8'h01, 8, 8, 1, alt, 1'b1);

      // Asynchronous reset mid-payload.
      send_frame(16, 8'h05, 40, 12, 2, alt, 1'b1);
      chk("rst_pre_busy", int'(bus.busy_o), 1);
      chk("rst_pre_len", int'(bus.len_o), 5);
      #3;
      resetn = 1'b0;
      #1;
      chk("rst_async_busy", int'(bus.busy_o), 0);
      chk("rst_async_len", int'(bus.len_o), 0);
      exp_len = '0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      send_frame(16, 8'h03, 24, 24, 1, alt, 1'b1);

      repeat (8) @(negedge clk);
      chk("final_len", int'(bus.len_o), 3);
      chk("leftover_expected", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1);
   end
endmodule
